// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with one output slot per channel.
// Define DEMUX_1_4_STATS_EN to add per-channel completed-transfer counters cnt0..cnt3.
module demux_1_4_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic [1:0]       up_sel,
    output logic             d0_valid,
    input  logic             d0_ready,
    output logic [WIDTH-1:0] d0_data,
    output logic             d1_valid,
    input  logic             d1_ready,
    output logic [WIDTH-1:0] d1_data,
    output logic             d2_valid,
    input  logic             d2_ready,
    output logic [WIDTH-1:0] d2_data,
    output logic             d3_valid,
    input  logic             d3_ready,
    output logic [WIDTH-1:0] d3_data
`ifdef DEMUX_1_4_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
`endif
);

    logic [3:0]       slot_valid;
    logic [WIDTH-1:0] slot_data [4];
    logic [3:0]       slot_ready;
    logic [3:0]       slot_free;
    logic             load;

    assign slot_ready = {d3_ready, d2_ready, d1_ready, d0_ready};
    assign slot_free  = ~slot_valid | slot_ready;

    // Ready looks only at the addressed slot, so a stalled channel blocks just its own beats.
    assign up_ready = slot_free[up_sel];
    assign load     = up_valid && up_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every slot sees pre-edge values.
            slot_valid <= '0;
            for (int n = 0; n < 4; n++) slot_data[n] <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (load && (up_sel == 2'(n))) begin
                    slot_valid[n] <= 1'b1;
                    slot_data[n]  <= up_data;
                end else if (slot_ready[n]) begin
                    slot_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign d0_valid = slot_valid[0];
    assign d1_valid = slot_valid[1];
    assign d2_valid = slot_valid[2];
    assign d3_valid = slot_valid[3];
    assign d0_data  = slot_data[0];
    assign d1_data  = slot_data[1];
    assign d2_data  = slot_data[2];
    assign d3_data  = slot_data[3];

`ifdef DEMUX_1_4_STATS_EN
    logic [CNT_W-1:0] cnt_q [4];

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (slot_valid[n] && slot_ready[n]) cnt_q[n] <= cnt_q[n] + 1'b1;
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed, table-driven bench for demux_1_4_stream; stats counters checked when DEMUX_1_4_STATS_EN is set.
module tb_demux_1_4_stream;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_data;
    logic [1:0]       up_sel;
    logic             d0_valid, d1_valid, d2_valid, d3_valid;
    logic             d0_ready, d1_ready, d2_ready, d3_ready;
    logic [WIDTH-1:0] d0_data, d1_data, d2_data, d3_data;
`ifdef DEMUX_1_4_STATS_EN
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

    demux_1_4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_sel(up_sel),
        .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_data(d0_data),
        .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_data(d1_data),
        .d2_valid(d2_valid), .d2_ready(d2_ready), .d2_data(d2_data),
        .d3_valid(d3_valid), .d3_ready(d3_ready), .d3_data(d3_data)
`ifdef DEMUX_1_4_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [1:0]  sel;
        logic [3:0]  data;
        logic [3:0]  rdy;    // {d3,d2,d1,d0}
        logic        ur;     // expected up_ready before the edge
        logic [3:0]  dv;     // expected {d3..d0}_valid after the edge
        logic [15:0] dd;     // expected {d3,d2,d1,d0}_data after the edge
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic vec(input logic r, input logic v, input logic [1:0] s, input logic [3:0] d,
                       input logic [3:0] rdy, input logic ur, input logic [3:0] dv, input logic [15:0] dd);
        vec_t t;
        t.rst = r; t.v = v; t.sel = s; t.data = d; t.rdy = rdy;
        t.ur = ur; t.dv = dv; t.dd = dd;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic [3:0] d,
                         input logic [3:0] rdy);
        rst = r; up_valid = v; up_sel = s; up_data = d;
        {d3_ready, d2_ready, d1_ready, d0_ready} = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'd0, 4'h0, 4'hf);

        // Reset: up_ready follows the free rule for every sel, nothing captured.
        vec(1, 1, 2'd0, 4'hf, 4'hf, 1, 4'b0000, 16'h0000);
        vec(1, 1, 2'd1, 4'hf, 4'hf, 1, 4'b0000, 16'h0000);
        vec(1, 1, 2'd2, 4'hf, 4'hf, 1, 4'b0000, 16'h0000);
        vec(1, 1, 2'd3, 4'hf, 4'hf, 1, 4'b0000, 16'h0000);
        // Routing a/b/c/d to channels 0..3.
        vec(0, 1, 2'd0, 4'ha, 4'hf, 1, 4'b0001, 16'h000a);
        vec(0, 1, 2'd1, 4'hb, 4'hf, 1, 4'b0010, 16'h00ba);
        vec(0, 1, 2'd2, 4'hc, 4'hf, 1, 4'b0100, 16'h0cba);
        vec(0, 1, 2'd3, 4'hd, 4'hf, 1, 4'b1000, 16'hdcba);
        vec(0, 0, 2'd0, 4'h0, 4'hf, 1, 4'b0000, 16'hdcba);
        // Backpressure on d2, in-order source.
        vec(0, 1, 2'd2, 4'h7, 4'b1011, 1, 4'b0100, 16'hd7ba);
        vec(0, 1, 2'd2, 4'h3, 4'b1011, 0, 4'b0100, 16'hd7ba);
        vec(0, 1, 2'd2, 4'h3, 4'b1011, 0, 4'b0100, 16'hd7ba);
        vec(0, 1, 2'd2, 4'h3, 4'hf,    1, 4'b0100, 16'hd3ba);
        vec(0, 1, 2'd0, 4'h5, 4'hf,    1, 4'b0001, 16'hd3b5);
        vec(0, 0, 2'd0, 4'h0, 4'hf,    1, 4'b0000, 16'hd3b5);
        // Drain and fill channel 1 back to back.
        vec(0, 1, 2'd1, 4'h1, 4'hf, 1, 4'b0010, 16'hd315);
        vec(0, 1, 2'd1, 4'h2, 4'hf, 1, 4'b0010, 16'hd325);
        vec(0, 1, 2'd1, 4'h3, 4'hf, 1, 4'b0010, 16'hd335);
        vec(0, 1, 2'd1, 4'h4, 4'hf, 1, 4'b0010, 16'hd345);
        vec(0, 0, 2'd1, 4'h0, 4'hf, 1, 4'b0000, 16'hd345);
        // d3 stalled holding 9; other channels still flow; reset drops 9.
        vec(0, 1, 2'd3, 4'h9, 4'b0111, 1, 4'b1000, 16'h9345);
        vec(0, 1, 2'd0, 4'he, 4'b0111, 1, 4'b1001, 16'h934e);
        vec(0, 1, 2'd3, 4'h1, 4'b0111, 0, 4'b1000, 16'h934e);
        vec(1, 0, 2'd3, 4'h0, 4'b0111, 0, 4'b0000, 16'h0000);
        // First accept right after reset release.
        vec(0, 1, 2'd0, 4'h6, 4'b0111, 1, 4'b0001, 16'h0006);
        vec(0, 0, 2'd3, 4'h0, 4'b0111, 1, 4'b0000, 16'h0006);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].rdy);
            #1;
            check($sformatf("v%0d_up_ready", i), 32'(up_ready), 32'(vecs[i].ur));
            tick();
            check($sformatf("v%0d_valid", i), 32'({d3_valid, d2_valid, d1_valid, d0_valid}), 32'(vecs[i].dv));
            check($sformatf("v%0d_data", i), 32'({d3_data, d2_data, d1_data, d0_data}), 32'(vecs[i].dd));
        end

        // Stall hold: d2 data must stay stable over several stalled cycles.
        drive(1'b0, 1'b1, 2'd2, 4'h8, 4'b1011);
        tick();
        drive(1'b0, 1'b1, 2'd2, 4'h2, 4'b1011);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold_d2_%0d", k), 32'({d2_valid, d2_data}), 32'({1'b1, 4'h8}));
        end

`ifdef DEMUX_1_4_STATS_EN
        drive(1'b1, 1'b0, 2'd0, 4'h0, 4'hf);
        tick();
        check("cnt_reset", 32'({cnt3, cnt2, cnt1, cnt0}), 32'h0);
        for (int k = 0; k < 256; k++) begin
            drive(1'b0, 1'b1, 2'd0, 4'(k), 4'hf);
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 4'h0, 4'hf);
        tick();
        check("cnt0_wrap", 32'(cnt0), 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 2'd2, 4'(k), 4'hf);
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 4'h0, 4'hf);
        tick();
        check("cnt2_five", 32'(cnt2), 32'd5);
        drive(1'b0, 1'b1, 2'd1, 4'h3, 4'b1101);
        tick();
        drive(1'b0, 1'b0, 2'd1, 4'h0, 4'b1101);
        tick();
        tick();
        check("cnt1_stalled", 32'(cnt1), 32'h0);
        check("cnt1_still_valid", 32'(d1_valid), 32'h1);
        check("cnt3_zero", 32'(cnt3), 32'h0);
        check("cnt0_still_zero", 32'(cnt0), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

- Registered 1-to-4 stream demultiplexer: one upstream valid/ready stream, each beat steered by its `up_sel` to one of four downstream valid/ready channels.
- Sits where one producer feeds four independent consumers; `mux_4_1`-style selection, opposite direction.
- One single-entry output register per channel, so a stalled channel blocks only beats addressed to it.

## Interface
Parameters:
- `WIDTH`, 4, data width of every channel
- `CNT_W`, 8, width of per-channel transfer counters (only with `DEMUX_1_4_STATS_EN`)

Ports:
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  synchronous reset, active-high
- `up_valid`  input  1  upstream beat present
- `up_ready`  output  1  upstream beat accepted this cycle when high together with `up_valid`
- `up_data`  input  WIDTH  upstream payload
- `up_sel`  input  2  destination channel 0..3 of current upstream beat
- `d0_valid`..`d3_valid`  output  1 each  channel N holds a beat
- `d0_ready`..`d3_ready`  input  1 each  channel N consumer accepts
- `d0_data`..`d3_data`  output  WIDTH each  channel N payload
- `cnt0`..`cnt3`  output  CNT_W each  completed transfers per channel (only with `DEMUX_1_4_STATS_EN`)

## Operation
- Per channel N: slot register `{dN_valid, dN_data}`; `dN_valid`/`dN_data` driven directly from flops.
- Slot N is free when `!dN_valid || dN_ready`.
- `up_ready = slot[up_sel] free`; combinational on `up_sel` and `dN_valid`/`dN_ready`; never depends on `up_valid` or `up_data`.
- Upstream handshake (`up_valid && up_ready`): slot `up_sel` loads `up_data`; its valid is set next cycle.
- Downstream handshake on N (`dN_valid && dN_ready`) with no new load into N: `dN_valid` clears next cycle.
- Drain and fill of the same slot in one cycle: new beat replaces old; `dN_valid` stays 1. Full throughput of 1 beat/cycle per channel.
- Beats to different channels are independent. A stalled channel N blocks upstream only while `up_sel == N`.
- Ordering is preserved per channel. There is no ordering across channels.
- While `dN_valid && !dN_ready`, `dN_data` is held stable.
- Non-selected slots are never written.
- `up_data`/`up_sel` are don't-care when `up_valid` is 0.
- X on `up_data` propagates to the selected channel's data unchanged.

## Timing
- Latency: 1 cycle from upstream handshake to `dN_valid` high.
- Reset values: all `dN_valid` = 0, all `dN_data` = 0, all `cntN` = 0.
- During reset, `up_ready` follows the free rule, but no beat is captured.
- Reset mid-operation: held beats are dropped, with no downstream handshake.
- First accept is possible in the first cycle with `rst` low.

## Configuration
- `DEMUX_1_4_STATS_EN` defined:
  - `cnt0`..`cnt3` exist.
  - `cntN` increments by 1 on each downstream handshake on channel N and wraps modulo 2^CNT_W.
  - Visible the cycle after the handshake.
- Undefined: counter ports and logic are absent; datapath behaviour is identical.

## Test plan
- **Reset:** hold `rst` 2 cycles, all `dN_ready` = 1 -> all `dN_valid` = 0, `dN_data` = 0, `up_ready` = 1 for every `up_sel`.
- **Routing:** all `dN_ready` = 1; beats (data, sel) 'ha/0, 'hb/1, 'hc/2, 'hd/3 on consecutive cycles -> each of d0..d3 shows its value exactly 1 cycle after accept, one valid pulse each.
- **Backpressure isolation:** `d2_ready` = 0; send 7/sel 2, then 3/sel 2, then 'h5/sel 0:
  - `d2_data` = 7 held.
  - `up_ready` = 0 while `up_sel` = 2.
  - Skipped ahead only if the source reorders. With in-order source, 'h5 waits.
  - Raise `d2_ready` -> 3 follows 7 with no gap, then 'h5 reaches d0.
- **Simultaneous drain/fill:** `d1_ready` = 1, back-to-back beats 1, 2, 3, 4 all sel 1 -> `d1_valid` high 4 consecutive cycles, data 1, 2, 3, 4, `up_ready` never low.
- **Reset mid-operation:** `d3` holds 'h9 with `d3_ready` = 0; pulse `rst` one cycle -> next cycle `d3_valid` = 0, `d3_data` = 0, 'h9 never delivered.
- **Stats (with `DEMUX_1_4_STATS_EN`, `CNT_W` = 8):** 256 transfers on channel 0 -> `cnt0` wraps to 0; 5 transfers on channel 2 -> `cnt2` = 5; `cnt1` = `cnt3` = 0; a stalled beat is not counted.
